// File: rtl/bus_arbiter_pkg.sv
// Shared bus-arbiter constants: channel count, owner index width,
// well-known master slots and active-low enable levels.
package bus_arbiter_pkg;
  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_W   = 2;

  localparam int BUS_MASTER_IF  = 0;
  localparam int BUS_MASTER_MEM = 1;
  localparam int BUS_MASTER_2   = 2;
  localparam int BUS_MASTER_3   = 3;

  // Request/grant lines are active low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration handshake bundle between the bus masters and the arbiter.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int OWNER_W   = 2
);
  logic [N_MASTERS-1:0] m_req_;
  logic [N_MASTERS-1:0] m_grnt_;
  logic [OWNER_W-1:0]   owner;
  logic                 bus_busy;
  logic                 hold_err;

  // Masters drive requests and see grants / bus status.
  modport master (output m_req_, input m_grnt_, owner, bus_busy, hold_err);
  // The arbiter consumes requests and produces grants / bus status.
  modport slave  (input m_req_, output m_grnt_, owner, bus_busy, hold_err);
endinterface

// File: rtl/bus_arbiter_rr_next_owner.sv
// Rotating priority search: first active-low request after the current
// owner, wrapping modulo N_MASTERS, never selecting the owner itself.
module rr_next_owner
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int OWNER_W   = 2
) (
  input  logic [OWNER_W-1:0]   owner,
  input  logic [N_MASTERS-1:0] req_,
  output logic [OWNER_W-1:0]   next_idx,
  output logic                 found
);
  logic [OWNER_W-1:0] idx;

  // Scan owner+1 .. owner+N-1; power-of-two width makes the wrap free.
  always_comb begin
    next_idx = owner;
    found    = 1'b0;
    idx      = owner;
    for (int k = 1; k < N_MASTERS; k++) begin
      idx = owner + OWNER_W'(k);
      if (!found && req_[idx] == ENABLE_) begin
        found    = 1'b1;
        next_idx = idx;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with parked grant and contended-hold watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = BUS_MASTER_CH,
  parameter int OWNER_W   = BUS_OWNER_W,
  parameter int MAX_HOLD  = 64
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  logic [OWNER_W-1:0]   owner_q, rr_idx, next_owner;
  logic [N_MASTERS-1:0] grnt_q;
  logic                 rr_found, contended;
  logic [15:0]          hold_cnt;
  logic                 hold_err_q;

  rr_next_owner #(.N_MASTERS(N_MASTERS), .OWNER_W(OWNER_W)) u_rr (
    .owner    (owner_q),
    .req_     (bus.m_req_),
    .next_idx (rr_idx),
    .found    (rr_found)
  );

  // Ownership moves only when the owner has released and someone else waits.
  always_comb begin
    next_owner = owner_q;
    if (bus.m_req_[owner_q] == DISABLE_ && rr_found)
      next_owner = rr_idx;
  end

  // Owner still requesting while another master has its request low.
  // grnt_q is high on every non-owner bit, so it masks the owner out.
  assign contended = (bus.m_req_[owner_q] == ENABLE_) &&
                     (|(~bus.m_req_ & grnt_q));

  // Owner index and one-hot-low grant share one next_owner value.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= '0;
      grnt_q  <= ~N_MASTERS'(1);
    end else begin
      owner_q <= next_owner;
      grnt_q  <= ~(N_MASTERS'(1) << next_owner);
    end
  end

  // Watchdog: count contended cycles (saturating), pulse once at MAX_HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      hold_err_q <= 1'b0;
    end else begin
      hold_err_q <= contended && (hold_cnt == 16'(MAX_HOLD - 1));
      if (contended)
        hold_cnt <= (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
      else
        hold_cnt <= '0;
    end
  end

  assign bus.owner    = owner_q;
  assign bus.m_grnt_  = grnt_q;
  assign bus.bus_busy = (bus.m_req_[owner_q] == ENABLE_);
  assign bus.hold_err = hold_err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (4 masters, MAX_HOLD=8).
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bus_arbiter_if #(.N_MASTERS(4), .OWNER_W(2)) bif ();

  bus_arbiter #(.N_MASTERS(4), .OWNER_W(2), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] own, input logic [3:0] gnt,
                           input logic busy);
    chk({tag, ".owner"}, 32'(bif.owner), 32'(own));
    chk({tag, ".grnt"},  32'(bif.m_grnt_), 32'(gnt));
    chk({tag, ".busy"},  32'(bif.bus_busy), 32'(busy));
  endtask

  initial begin
    // Reset then idle
    reset = 1'b1;
    bif.m_req_ = 4'b1111;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_state("idle", 2'd0, 4'b1110, 1'b0);
      chk("idle.err", 32'(bif.hold_err), 32'd0);
    end

    // Handover 0 -> 1; busy is combinational as soon as owner requests
    bif.m_req_ = 4'b1110;
    #1;
    chk("hold0.busy_comb", 32'(bif.bus_busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("hold0", 2'd0, 4'b1110, 1'b1);
    end
    bif.m_req_ = 4'b1101;
    tick();
    chk_state("handover", 2'd1, 4'b1101, 1'b1);

    // Walk owner to 3: 1 -> 2 -> 3
    bif.m_req_ = 4'b1011;
    tick();
    chk_state("to2", 2'd2, 4'b1011, 1'b1);
    bif.m_req_ = 4'b0111;
    tick();
    chk_state("to3", 2'd3, 4'b0111, 1'b1);

    // Wrap-around: 3 releases, 0 and 2 request -> 0 wins, then 2
    bif.m_req_ = 4'b1010;
    tick();
    chk_state("wrap", 2'd0, 4'b1110, 1'b1);
    bif.m_req_ = 4'b1011;
    tick();
    chk_state("fair", 2'd2, 4'b1011, 1'b1);

    // Parking on 2, then zero-latency re-request
    bif.m_req_ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state("park", 2'd2, 4'b1011, 1'b0);
    end
    bif.m_req_ = 4'b1011;
    #1;
    chk("park.busy_comb", 32'(bif.bus_busy), 32'd1);
    chk("park.grnt_comb", 32'(bif.m_grnt_), 32'b1011);
    tick();
    chk_state("park_req", 2'd2, 4'b1011, 1'b1);

    // Watchdog: move to owner 1 (scan 3,0,1), then hold while 0 waits
    bif.m_req_ = 4'b1101;
    tick();
    chk_state("to1", 2'd1, 4'b1101, 1'b1);
    chk("to1.cnt", 32'(dut.hold_cnt), 32'd0);
    bif.m_req_ = 4'b1100;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("wd.err", 32'(bif.hold_err), (i == 8) ? 32'd1 : 32'd0);
      chk("wd.owner", 32'(bif.owner), 32'd1);
      chk("wd.cnt", 32'(dut.hold_cnt), 32'(i));
    end
    // Release with 0 and 2 waiting: 2 is nearer after 1
    bif.m_req_ = 4'b1010;
    tick();
    chk_state("wd_rel", 2'd2, 4'b1011, 1'b1);
    chk("wd_rel.cnt", 32'(dut.hold_cnt), 32'd0);
    chk("wd_rel.err", 32'(bif.hold_err), 32'd0);

    // Reset mid-transfer with owner 3 busy and contended
    bif.m_req_ = 4'b0111;
    tick();
    chk_state("to3b", 2'd3, 4'b0111, 1'b1);
    bif.m_req_ = 4'b0110;
    tick();
    tick();
    chk("mid.cnt_pre", 32'(dut.hold_cnt), 32'd2);
    reset = 1'b1;
    tick();
    chk("rst.owner", 32'(bif.owner), 32'd0);
    chk("rst.grnt", 32'(bif.m_grnt_), 32'b1110);
    chk("rst.cnt", 32'(dut.hold_cnt), 32'd0);
    chk("rst.err", 32'(bif.hold_err), 32'd0);
    reset = 1'b0;
    tick();
    chk_state("post_rst", 2'd0, 4'b1110, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared system bus used by the instruction-fetch and memory-stage bus interfaces, plus any additional bus masters.
- Every master drives an active-low request and receives an active-low grant. The bus address and data multiplexers use the registered owner index.
- The grant is parked on the last owner when no master requests, so an uncontested master has a zero-cycle grant.
- A hold watchdog flags a master that keeps the bus while others wait.

Parameters:
- N_MASTERS, 4, number of bus masters (power of two, 2..8).
- OWNER_W, 2, width of the owner index, equal to log2(N_MASTERS).
- MAX_HOLD, 64, contended-hold cycle count that raises hold_err (range 1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- m_req_  in  N_MASTERS  per-master bus request, active low; bit i belongs to master i.
- m_grnt_  out  N_MASTERS  per-master bus grant, active low, registered, exactly one bit low at all times.
- owner  out  OWNER_W  index of the current grant holder, registered; drives the bus muxes.
- bus_busy  out  1  high while the current owner's m_req_ is low (combinational from owner and m_req_).
- hold_err  out  1  one-cycle pulse when the contended hold count reaches MAX_HOLD.

Behaviour:
- Reset (clk edge with reset=1):
  - owner=0 and m_grnt_ = all ones except bit 0 = 0 (parked on master 0).
  - hold_cnt=0 and hold_err=0.
  - reset takes priority over every other event, including mid-transfer. The transfer in progress is abandoned, and masters observe grant-to-0 on the next cycle.
- Arbitration is evaluated every cycle from the registered owner and the sampled m_req_:
  - Owner keeps its request (m_req_[owner]=0): owner is unchanged. No preemption under any condition.
  - Owner has released (m_req_[owner]=1): scan indices owner+1, owner+2, ... modulo N_MASTERS (wrap-around), excluding owner itself. The first index with m_req_ low becomes the next owner.
  - No other requester: owner is unchanged (parking).
- Latency:
  - A grant change appears on m_grnt_/owner one clock after the owner's m_req_ rises, provided the new requester is low in that same cycle.
  - A request from the parked owner needs 0 cycles, because its grant is already low.
- One-hot invariant: m_grnt_ == ~(1 << owner) every cycle, and both are updated on the same edge from one next_owner value.
- Simultaneous events:
  - Release by the owner and several new requests in the same cycle: the lowest rotational distance from owner wins.
  - The owner releases and re-requests in the next cycle while others wait: the others win first (round-robin fairness).
  - Worst-case wait for any master is N_MASTERS-1 ownership tenures.
- Hold watchdog (hold_cnt, 16 bits):
  - Contended means m_req_[owner]=0 and any other m_req_ bit is low. In a contended cycle hold_cnt increments, saturating at 16'hFFFF.
  - Otherwise, or on an owner change, hold_cnt clears to 0.
  - hold_err=1 for exactly the one cycle after hold_cnt transitions from MAX_HOLD-1 to MAX_HOLD. It does not repeat until hold_cnt clears.
  - hold_err is advisory and does not affect arbitration.
- Undriven or X request bits are not required to be handled; the bench drives all bits.

Decomposition:
- Shared package/header: the BUS_MASTER_CH constant (= N_MASTERS), BUS_OWNER_W, the master index constants (BUS_MASTER_IF=0, BUS_MASTER_MEM=1, BUS_MASTER_2=2, BUS_MASTER_3=3) and the active-low ENABLE_/DISABLE_ macros already used by the bus interfaces.
- One natural sub-module: rr_next_owner, a combinational rotating priority search (current owner plus request vector gives the next owner and a found flag).
- Owner/grant registers and the watchdog counter live in bus_arbiter.

Test Plan:
- Reset then idle:
  - Stimulus: reset high 2 cycles, then low, with m_req_=4'b1111.
  - Required: owner=0, m_grnt_=4'b1110, bus_busy=0 and hold_err=0, held for 10 cycles.
- Handover:
  - Stimulus: owner 0 holds with m_req_=4'b1110 for 3 cycles, then m_req_=4'b1101.
  - Required: the next cycle gives owner=1 and m_grnt_=4'b1101. bus_busy=1 from that cycle.
- Wrap-around and fairness:
  - Stimulus: owner=3, masters 0 and 2 both request, master 3 releases.
  - Required: owner becomes 0, not 2. After master 0 releases, owner becomes 2.
- Parking zero latency:
  - Stimulus: owner=2 releases with no other requester, then re-requests 5 cycles later.
  - Required: owner stays 2 throughout and m_grnt_[2]=0 continuously.
- Watchdog:
  - Stimulus: MAX_HOLD=8; owner 1 holds while master 0 requests continuously.
  - Required: hold_err pulses for exactly 1 cycle, the cycle after hold_cnt reaches 8, and owner remains 1. When owner 1 releases, owner becomes 2 if master 2 is requesting, else 0, and hold_cnt returns to 0.
- Reset mid-transfer:
  - Stimulus: owner=3 busy and reset asserted for 1 cycle.
  - Required: the next cycle gives owner=0, m_grnt_=4'b1110 and hold_cnt=0, regardless of m_req_.
